// File: rtl/ushift_seq_ctrl_pkg.sv
// Shared encodings for the universal shift register sequencer.
// Op codes, register mode codes and controller states.
package ushift_seq_ctrl_pkg;

  localparam logic [1:0] OP_TX_MSB = 2'b00;
  localparam logic [1:0] OP_TX_LSB = 2'b01;
  localparam logic [1:0] OP_RX_MSB = 2'b10;
  localparam logic [1:0] OP_RX_LSB = 2'b11;

  // {S1,S0}: SHL moves toward MSB, SHR moves toward LSB
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  function automatic logic is_rx(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_lsb(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/ushift_seq_ctrl.sv
// Sequencer driving a universal shift register as a serial
// transmitter/receiver behind request/response handshakes.
module ushift_seq_ctrl
  import ushift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Req_valid,
  output logic             Req_ready,
  input  logic [1:0]       Req_op,
  input  logic [WIDTH-1:0] Req_data,
  output logic             Rsp_valid,
  input  logic             Rsp_ready,
  output logic [WIDTH-1:0] Rsp_data,
  input  logic             Ser_in,
  output logic             Ser_out,
  output logic             Ser_en,
  output logic             Reg_S1,
  output logic             Reg_S0,
  output logic             Reg_L,
  output logic             Reg_R,
  output logic [WIDTH-1:0] Reg_Datain,
  output logic             Reg_Rst,
  input  logic [WIDTH-1:0] Reg_q
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] datain_q;
  logic             ser_en_q;
  logic             rsp_valid_q;
  logic             shifting;
  logic             rx;
  logic             lsb;

  // Control FSM; mode/Ser_en/Rsp_valid registered for the next state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_TX_MSB;
      data_q      <= '0;
      mode_q      <= MODE_HOLD;
      datain_q    <= '0;
      ser_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (Req_valid) begin
            op_q     <= Req_op;
            data_q   <= Req_data;
            mode_q   <= MODE_LOAD;
            datain_q <= is_rx(Req_op) ? '0 : Req_data;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_q    <= '0;
          mode_q   <= is_lsb(op_q) ? MODE_SHR : MODE_SHL;
          datain_q <= '0;
          ser_en_q <= 1'b1;
          state_q  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            mode_q      <= MODE_HOLD;
            ser_en_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (Rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Serial pin and fill bits follow the live register contents
  always_comb begin
    shifting  = (state_q == ST_SHIFT);
    rx        = is_rx(op_q);
    lsb       = is_lsb(op_q);
    Req_ready = (state_q == ST_IDLE);
    Ser_out   = 1'b0;
    Reg_L     = 1'b0;
    Reg_R     = 1'b0;
    if (shifting && !rx)
      Ser_out = lsb ? Reg_q[0] : Reg_q[WIDTH-1];
    if (shifting && rx && !lsb)
      Reg_L = Ser_in;
    if (shifting && rx && lsb)
      Reg_R = Ser_in;
    Rsp_data   = rx ? Reg_q : data_q;
    Rsp_valid  = rsp_valid_q;
    Ser_en     = ser_en_q;
    Reg_S1     = mode_q[1];
    Reg_S0     = mode_q[0];
    Reg_Datain = datain_q;
    Reg_Rst    = ~Rst_n;
  end

endmodule

// File: tb/tb_ushift_seq_ctrl.sv
// Bench for ushift_seq_ctrl with a behavioural 4-bit universal
// shift register closing the loop through Reg_q.
module tb_ushift_seq_ctrl;

  localparam int W = 4;

  logic         Clk;
  logic         Rst_n;
  logic         Req_valid;
  logic         Req_ready;
  logic [1:0]   Req_op;
  logic [W-1:0] Req_data;
  logic         Rsp_valid;
  logic         Rsp_ready;
  logic [W-1:0] Rsp_data;
  logic         Ser_in;
  logic         Ser_out;
  logic         Ser_en;
  logic         Reg_S1;
  logic         Reg_S0;
  logic         Reg_L;
  logic         Reg_R;
  logic [W-1:0] Reg_Datain;
  logic         Reg_Rst;
  logic [W-1:0] Reg_q;

  int n_chk;
  int n_fail;
  int cyc;
  int acc_cyc;
  int hs_cyc;

  ushift_seq_ctrl #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Req_valid (Req_valid),
    .Req_ready (Req_ready),
    .Req_op    (Req_op),
    .Req_data  (Req_data),
    .Rsp_valid (Rsp_valid),
    .Rsp_ready (Rsp_ready),
    .Rsp_data  (Rsp_data),
    .Ser_in    (Ser_in),
    .Ser_out   (Ser_out),
    .Ser_en    (Ser_en),
    .Reg_S1    (Reg_S1),
    .Reg_S0    (Reg_S0),
    .Reg_L     (Reg_L),
    .Reg_R     (Reg_R),
    .Reg_Datain(Reg_Datain),
    .Reg_Rst   (Reg_Rst),
    .Reg_q     (Reg_q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // the universal shift register datapath
  always @(posedge Clk) begin
    if (Reg_Rst) Reg_q <= '0;
    else begin
      case ({Reg_S1, Reg_S0})
        2'b11:   Reg_q <= Reg_Datain;
        2'b10:   Reg_q <= {Reg_q[W-2:0], Reg_L};
        2'b01:   Reg_q <= {Reg_R, Reg_q[W-1:1]};
        default: Reg_q <= Reg_q;
      endcase
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic junk(input bit keep);
    Req_valid = keep ? 1'b1 : 1'($urandom);
    Req_op    = 2'($urandom);
    Req_data  = W'($urandom);
    Rsp_ready = 1'($urandom);
  endtask

  // one full transaction; rxb[i] is the i-th bit on the wire
  task automatic run_txn(input logic [1:0]   op,
                         input logic [W-1:0] data,
                         input logic [W-1:0] rxb,
                         input int           bp,
                         input bit           keep);
    logic [W-1:0] exp_w;
    logic [W-1:0] exp_q;
    logic         eb;
    exp_w = data;
    if (op[1]) begin
      for (int i = 0; i < W; i++) begin
        if (op[0]) exp_w[i] = rxb[i];
        else exp_w[W-1-i] = rxb[i];
      end
    end
    exp_q = op[1] ? exp_w : '0;
    @(negedge Clk);
    Req_valid = 1'b1;
    Req_op    = op;
    Req_data  = data;
    Rsp_ready = 1'($urandom);
    #1;
    chk("idle_ready", Req_ready, 1);
    chk("idle_rspv", Rsp_valid, 0);
    chk("idle_seren", Ser_en, 0);
    @(posedge Clk);
    #1 acc_cyc = cyc;
    @(negedge Clk);
    junk(keep);
    #1;
    chk("load_mode", {Reg_S1, Reg_S0}, 2'b11);
    chk("load_din", Reg_Datain, op[1] ? '0 : data);
    chk("load_seren", Ser_en, 0);
    chk("load_ready", Req_ready, 0);
    for (int i = 0; i < W; i++) begin
      @(negedge Clk);
      junk(keep);
      Ser_in = rxb[i];
      #1;
      eb = op[1] ? 1'b0 : (op[0] ? data[i] : data[W-1-i]);
      chk("sh_seren", Ser_en, 1);
      chk("sh_serout", Ser_out, eb);
      chk("sh_mode", {Reg_S1, Reg_S0}, op[0] ? 2'b01 : 2'b10);
      chk("sh_rspv", Rsp_valid, 0);
    end
    for (int j = 0; j <= bp; j++) begin
      @(negedge Clk);
      junk(keep);
      Ser_in    = 1'($urandom);
      Rsp_ready = (j == bp);
      #1;
      chk("dn_rspv", Rsp_valid, 1);
      chk("dn_data", Rsp_data, exp_w);
      chk("dn_ready", Req_ready, 0);
      chk("dn_mode", {Reg_S1, Reg_S0}, 2'b00);
      chk("dn_seren", Ser_en, 0);
      chk("dn_serout", Ser_out, 0);
      chk("dn_regq", Reg_q, exp_q);
    end
    @(posedge Clk);
    #1 hs_cyc = cyc;
    if (!keep) Req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1;
    cyc       = 0;
    n_chk     = 0;
    n_fail    = 0;
    Rst_n     = 1'b0;
    Req_valid = 1'b0;
    Req_op    = '0;
    Req_data  = '0;
    Rsp_ready = 1'b0;
    Ser_in    = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", Req_ready, 1);
    chk("rst_rspv", Rsp_valid, 0);
    chk("rst_seren", Ser_en, 0);
    chk("rst_serout", Ser_out, 0);
    chk("rst_mode", {Reg_S1, Reg_S0}, 2'b00);
    chk("rst_lr", {Reg_L, Reg_R}, 2'b00);
    chk("rst_din", Reg_Datain, 0);
    chk("rst_regrst", Reg_Rst, 1);
    chk("rst_regq", Reg_q, 0);
    Rst_n = 1'b1;
    #1 chk("rel_regrst", Reg_Rst, 0);

    run_txn(2'b00, 4'b1011, 4'b0000, 0, 0);
    chk("lat_tx", hs_cyc - acc_cyc, W + 2);
    run_txn(2'b01, 4'b1011, 4'b0000, 0, 0);
    run_txn(2'b10, 4'b0000, 4'b0011, 0, 0);
    run_txn(2'b11, 4'b0000, 4'b0011, 0, 0);
    run_txn(2'b10, 4'b0101, 4'b1010, 3, 0);

    // back-to-back with both valids held high
    run_txn(2'b00, 4'b0110, 4'b0000, 0, 1);
    h1 = hs_cyc;
    run_txn(2'b10, 4'b1111, 4'b1001, 0, 1);
    chk("b2b_gap", acc_cyc - h1, 1);
    Req_valid = 1'b0;

    // reset in the middle of shifting
    @(negedge Clk);
    Req_valid = 1'b1;
    Req_op    = 2'b00;
    Req_data  = 4'b1111;
    Rsp_ready = 1'b0;
    repeat (3) @(negedge Clk);
    Req_valid = 1'b0;
    #1 chk("mid_seren", Ser_en, 1);
    Rst_n = 1'b0;
    #1;
    chk("mr_ready", Req_ready, 1);
    chk("mr_rspv", Rsp_valid, 0);
    chk("mr_seren", Ser_en, 0);
    chk("mr_mode", {Reg_S1, Reg_S0}, 2'b00);
    chk("mr_regrst", Reg_Rst, 1);
    @(posedge Clk);
    #1 chk("mr_regq", Reg_q, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      #1 chk("mr_norsp", Rsp_valid, 0);
    end

    for (int n = 0; n < 24; n++) begin
      run_txn(2'($urandom), W'($urandom), W'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
      Req_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge Clk);
        Rsp_ready = 1'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
